// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage arithmetic blocks:
// multiplier state encoding, default operand width and a two's-complement negate.
package alu_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int PROD_W    = 2 * WIDTH_DEF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        SIGN = 2'd2,
        DONE = 2'd3
    } mul_state_e;

    // Two's-complement negate at full product width; narrower products are
    // zero-extended in and truncated out, which gives the same low bits.
    function automatic logic [PROD_W-1:0] tc_negate(input logic [PROD_W-1:0] v);
        return ~v + 1'b1;
    endfunction

endpackage

// File: rtl/mul_add_row.sv
// WIDTH-bit ripple-carry adder built from full-adder slices, carry-in tied low.
// Purely combinational; it forms one partial sum per multiplier iteration.
module mul_add_row #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0] carry;

    assign carry[0] = 1'b0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_slice
        assign sum[i]       = a[i] ^ b[i] ^ carry[i];
        assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign cout = carry[WIDTH];

endmodule

// File: rtl/alu_iter_multiplier.sv
// Iterative shift-add multiplier sitting beside the execute-stage ALU.
// Operands are reduced to magnitudes on accept, multiplied unsigned over
// WIDTH iterations, and the sign is applied in one final fix-up cycle.
module alu_iter_multiplier
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = 6
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    start_i,
    input  logic                    signed_i,
    input  logic signed [WIDTH-1:0] src1_i,
    input  logic signed [WIDTH-1:0] src2_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [2*WIDTH-1:0]      product_o
);

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    mul_state_e         state;
    mul_state_e         state_nxt;
    logic               accept;

    logic               neg;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic [WIDTH-1:0]   acc_hi;
    logic [CNT_W-1:0]   cnt;

    logic [WIDTH-1:0]   addend;
    logic [WIDTH-1:0]   row_sum;
    logic               row_cout;
    logic [2*WIDTH-1:0] prod_raw;
    logic [PROD_W-1:0]  prod_neg;

    // Magnitude of a possibly signed operand; the most-negative value maps to
    // 2**(WIDTH-1), which still fits the unsigned WIDTH-bit register.
    function automatic logic [WIDTH-1:0] mag_of(input logic signed [WIDTH-1:0] v,
                                                input logic                    sgn);
        logic [WIDTH-1:0] u;
        u = v;
        return (sgn && v[WIDTH-1]) ? (~u + 1'b1) : u;
    endfunction

    mul_add_row #(
        .WIDTH (WIDTH)
    ) u_add_row (
        .a    (acc_hi),
        .b    (addend),
        .sum  (row_sum),
        .cout (row_cout)
    );

    assign addend   = mplier[0] ? mcand : '0;
    assign prod_raw = {acc_hi, mplier};
    assign prod_neg = tc_negate(PROD_W'(prod_raw));

    // State register; reset abandons any operation in flight.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode, accept strobe and handshake outputs.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        busy_o    = 1'b0;
        done_o    = 1'b0;
        case (state)
            IDLE: begin
                if (start_i) begin
                    state_nxt = RUN;
                    accept    = 1'b1;
                end
            end
            RUN: begin
                busy_o = 1'b1;
                if (cnt == LAST_ITER) begin
                    state_nxt = SIGN;
                end
            end
            SIGN: begin
                busy_o    = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                done_o = 1'b1;
                if (start_i) begin
                    state_nxt = RUN;
                    accept    = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand latch, shift-add iteration and sign fix-up of the product.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            neg       <= 1'b0;
            mcand     <= '0;
            mplier    <= '0;
            acc_hi    <= '0;
            cnt       <= '0;
            product_o <= '0;
        end else if (accept) begin
            neg    <= signed_i & (src1_i[WIDTH-1] ^ src2_i[WIDTH-1]);
            mcand  <= mag_of(src1_i, signed_i);
            mplier <= mag_of(src2_i, signed_i);
            acc_hi <= '0;
            cnt    <= '0;
        end else if (state == RUN) begin
            acc_hi <= {row_cout, row_sum[WIDTH-1:1]};
            mplier <= {row_sum[0], mplier[WIDTH-1:1]};
            cnt    <= cnt + 1'b1;
        end else if (state == SIGN) begin
            product_o <= neg ? prod_neg[2*WIDTH-1:0] : prod_raw;
        end
    end

endmodule
